arb8_rr_ctrl: RTL and testbench

Round-robin arbiter and sequencer for an 8-way shared resource. It accepts up to eight request lines, selects one owner per tenure, and drives a one-hot grant bus. The grant bus is produced by a 3-to-8 decode built from two enabled 2-to-4 decoder stages, with the arbiter's busy state acting as the decoder enable. It sits between requesting units and the shared datapath that they take turns to drive.

---
 rtl/arb8_rr_ctrl_if.sv | 28 ++
 rtl/arb8_rr_ctrl.sv | 145 ++++++++++++++
 tb/tb_arb8_rr_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/arb8_rr_ctrl_if.sv
// Request/grant bundle between the 8-way round-robin arbiter (master) and
// the requesting units (slave).
interface arb8_rr_ctrl_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;

    modport master (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/arb8_rr_ctrl.sv
// 8-way round-robin arbiter/sequencer with a one-hot grant built from two enabled 2-to-4 decoders.
// Optional forced release after HOLD_MAX cycles is enabled by defining ARB_HOLD_TIMEOUT_EN.

module arb8_dec2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end
endmodule

module arb8_rr_ctrl #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CW       = 4
) (
    input  logic            clk,
    input  logic            resetn,
    arb8_rr_ctrl_if.master  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (HOLD_MAX < 1 || HOLD_MAX > (2 ** CW) - 1) begin : g_bad_hold
        $error("arb8_rr_ctrl: HOLD_MAX must lie in 1..2^CW-1");
    end

    state_t     state, state_n;
    logic [2:0] idx_r, idx_n;
    logic [2:0] ptr, ptr_n;
    logic       to_r, to_n;
    logic [2:0] pick, probe;
    logic       found;
    logic       owner_req;
    logic       expire;
    logic       release_ev;
    logic       busy;
    logic       en_lo, en_hi;
    logic [3:0] gnt_lo, gnt_hi;

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [CW-1:0] cnt, cnt_n;

    assign expire = (cnt == CW'(HOLD_MAX - 1));
`else
    assign expire = 1'b0;
`endif

    // Rotating scan: first requester at or after ptr wins, so the last owner ranks lowest.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        probe = ptr;
        for (int unsigned i = 0; i < 8; i++) begin
            probe = ptr + 3'(i);
            if (!found && bus.req[probe]) begin
                found = 1'b1;
                pick  = probe;
            end
        end
    end

    assign owner_req  = bus.req[idx_r];
    assign release_ev = bus.done | ~owner_req | expire;

    always_comb begin
        state_n = state;
        idx_n   = idx_r;
        ptr_n   = ptr;
        to_n    = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    idx_n   = pick;
                    state_n = GRANT;
`ifdef ARB_HOLD_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            GRANT: begin
                if (release_ev) begin
                    ptr_n   = idx_r + 3'd1;
                    state_n = IDLE;
                    // A coincident done makes this an ordinary release, not a timeout.
                    to_n    = expire & ~bus.done;
                end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
                    cnt_n = cnt + CW'(1);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            idx_r <= '0;
            ptr   <= '0;
            to_r  <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
            idx_r <= idx_n;
            ptr   <= ptr_n;
            to_r  <= to_n;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt   <= cnt_n;
`endif
        end
    end

    assign busy  = (state == GRANT);
    assign en_lo = busy & ~idx_r[2];
    assign en_hi = busy & idx_r[2];

    arb8_dec2to4 u_dec_lo (
        .en  (en_lo),
        .sel (idx_r[1:0]),
        .y   (gnt_lo)
    );

    arb8_dec2to4 u_dec_hi (
        .en  (en_hi),
        .sel (idx_r[1:0]),
        .y   (gnt_hi)
    );

    assign bus.gnt     = {gnt_hi, gnt_lo};
    assign bus.gnt_idx = idx_r;
    assign bus.busy    = busy;
    assign bus.timeout = to_r;
endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// Scoreboard bench for arb8_rr_ctrl: directed steps queue expected outputs,
// a negedge monitor pops and compares them.
module tb_arb8_rr_ctrl;
    logic clk = 1'b0;
    logic resetn;

    arb8_rr_ctrl_if bus ();

    arb8_rr_ctrl #(
        .HOLD_MAX (4),
        .CW       (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       busy;
        logic       to;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic void compare(input exp_t e);
        vectors++;
        if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.busy !== e.busy || bus.timeout !== e.to) begin
            miscompares++;
            $display("FAIL %s: got gnt=%02h idx=%0d busy=%0b timeout=%0b, want gnt=%02h idx=%0d busy=%0b timeout=%0b",
                     e.tag, bus.gnt, bus.gnt_idx, bus.busy, bus.timeout, e.gnt, e.idx, e.busy, e.to);
        end
    endfunction

    task automatic step(input logic [7:0] r, input logic d, input logic [7:0] g,
                        input logic [2:0] ix, input logic b, input logic t, input string tag);
        exp_t e;
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        #1;
        e.gnt  = g;
        e.idx  = ix;
        e.busy = b;
        e.to   = t;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        exp_t z;
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        z.gnt  = 8'h00;
        z.idx  = 3'd0;
        z.busy = 1'b0;
        z.to   = 1'b0;
        z.tag  = tag;
        compare(z);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                compare(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] oh;
        resetn   = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        do_reset("reset_init");

        step(8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "first_grant0");
        step(8'h05, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "done_release0");
        step(8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, "next_grant2");
        step(8'h05, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, "done_release2");

        do_reset("reset_before_rr");
        for (int k = 0; k < 9; k++) begin
            oh = 8'h01 << (k % 8);
            step(8'hFF, 1'b0, oh,    3'(k % 8), 1'b1, 1'b0, "rr_grant");
            step(8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, 1'b0, "rr_turnaround");
        end

        step(8'h88, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "grant3");
        step(8'h88, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, "hold3");
        step(8'h80, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, "owner3_withdraw");
        step(8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "grant7_after_drop");
        step(8'h83, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0, "nonowner_change");
        step(8'h80, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, "release7");

        step(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "grant1_wrap");
        step(8'h00, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, "drop_and_done");
        step(8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, "idle_no_req");

        step(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "hold_grant");
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "hold_count");
        end
        step(8'h02, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1, "timeout_pulse");
        step(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "regrant_after_timeout");
        for (int i = 0; i < 3; i++) begin
            step(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "hold_count2");
        end
        step(8'h02, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, "done_and_timeout");
`else
        for (int i = 0; i < 100; i++) begin
            step(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0, "hold_no_timeout");
        end
        step(8'h02, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, "hold_release");
`endif
        step(8'h00, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, "idle_after_hold");

        step(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0, "grant6");
        do_reset("reset_mid_tenure");
        step(8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, "grant0_ptr_reset");
        step(8'h41, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, "release0_final");
        step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, "idle_final");

        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
